// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encodings, port ids and memory geometry defaults
package dmem_arbiter_pkg;
  localparam int DMEM_DATA_WIDTH = 8;
  localparam int DMEM_ADDR_BITS = 5;
  localparam logic PORT_CU = 1'b0;
  localparam logic PORT_LD = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic valid,
  output logic win
);
  assign valid = req0 | req1;
  assign win = (req0 & req1) ? prio : (req1 ? PORT_LD : PORT_CU);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a 1-cycle synchronous data memory between CU and loader ports
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_BITS = DMEM_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  w_r0,
  input  logic [ADDR_BITS-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  w_r1,
  input  logic [ADDR_BITS-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_t state, nxt;
  logic prio, win, wr, valid, pick;
  logic n_prio, n_win, n_wr, n_gnt0, n_gnt1, n_done0, n_done1, n_en, n_we;
  logic [ADDR_BITS-1:0] n_addr;
  logic [DATA_WIDTH-1:0] n_wdata, n_rdata0, n_rdata1;

  rr_pick2 u_pick (.req0(req0), .req1(req1), .prio(prio), .valid(valid), .win(pick));

  always_comb begin
    nxt = IDLE;
    n_prio = prio;
    n_win = win;
    n_wr = wr;
    n_gnt0 = 1'b0;
    n_gnt1 = 1'b0;
    n_done0 = 1'b0;
    n_done1 = 1'b0;
    n_en = 1'b0;
    n_we = 1'b0;
    n_addr = mem_addr;
    n_wdata = mem_wdata;
    n_rdata0 = rdata0;
    n_rdata1 = rdata1;
    case (state)
      IDLE: if (valid) begin
        nxt = ISSUE;
        n_win = pick;
        n_wr = pick ? w_r1 : w_r0;
        n_en = 1'b1;
        n_we = n_wr;
        n_addr = pick ? addr1 : addr0;
        n_wdata = pick ? wdata1 : wdata0;
        n_gnt0 = ~pick;
        n_gnt1 = pick;
        n_prio = ~pick;
      end
      ISSUE: nxt = RESP;
      RESP: begin
        n_done0 = ~win;
        n_done1 = win;
        n_rdata0 = (!wr && !win) ? mem_rdata : rdata0;
        n_rdata1 = (!wr && win) ? mem_rdata : rdata1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= PORT_CU;
      win <= PORT_CU;
      wr <= 1'b0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= nxt;
      prio <= n_prio;
      win <= n_win;
      wr <= n_wr;
      gnt0 <= n_gnt0;
      gnt1 <= n_gnt1;
      done0 <= n_done0;
      done1 <= n_done1;
      mem_en <= n_en;
      mem_we <= n_we;
      mem_addr <= n_addr;
      mem_wdata <= n_wdata;
      rdata0 <= n_rdata0;
      rdata1 <= n_rdata1;
    end
  end
endmodule
